// File: rtl/mul_seq_radix4.sv
// Radix-4 sequential unsigned multiplier: retires 2 bits of B per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b (operands);
//        out_valid/out_ready/out_z (2*WIDTH product); busy (CALC or DONE).
module mul_seq_radix4 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_z,
  output logic                 busy
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
    $error("mul_seq_radix4: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic               w_calc;
  logic               w_last;
  logic [WIDTH+1:0]   w_pp;
  logic [2*WIDTH-1:0] w_pp_sh;

  // Digit partial product A*d, d in 0..3.
  always_comb begin
    w_pp = '0;
    unique case (r_b[1:0])
      2'd0: w_pp = '0;
      2'd1: w_pp = {2'b00, r_a};
      2'd2: w_pp = {1'b0, r_a, 1'b0};
      2'd3: w_pp = {1'b0, r_a, 1'b0} + {2'b00, r_a};
      default: w_pp = '0;
    endcase
  end

  // Weight of digit cnt is 4^cnt; top digit still fits in 2*WIDTH.
  assign w_pp_sh = (2*WIDTH)'(w_pp) << {r_cnt, 1'b0};
  assign w_last  = (r_cnt == CW'(DIGITS - 1));
  assign w_calc  = (r_state == S_CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    w_accept  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_calc) begin
      r_acc <= r_acc + w_pp_sh;
      r_b   <= r_b >> 2;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Held after the handshake until the next accept clears it.
  assign out_z = r_acc;

endmodule

// File: tb/tb_mul_seq_radix4.sv
// Directed-vector bench for mul_seq_radix4 (WIDTH=32 and WIDTH=4).
// Covers latency, backpressure, reset mid-op and input changes mid-CALC.
module tb_mul_seq_radix4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_z;
  logic        busy;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [3:0]  s_a = '0;
  logic [3:0]  s_b = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [7:0]  s_z;
  logic        s_busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mul_seq_radix4 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .busy      (busy)
  );

  mul_seq_radix4 #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_a      (s_a),
    .in_b      (s_b),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_z     (s_z),
    .busy      (s_busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          bp;
    logic [63:0] z;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input int bp, output logic [63:0] z,
                        output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_accept", 64'(in_ready), 64'd1);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    lat = 0;
    while (!out_valid && lat < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a     = $urandom;
      in_b     = $urandom;
      @(posedge clk);
      #1;
      lat++;
    end
    z = out_z;
    in_valid = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_z", out_z, z);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    chk("post_hs_out_valid", 64'(out_valid), 64'd0);
    chk("post_hs_hold_z", out_z, z);
  endtask

  task automatic do_mul4(input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp);
    int lat;
    @(negedge clk);
    chk("w4_ready", 64'(s_in_ready), 64'd1);
    s_a        = a;
    s_b        = b;
    s_in_valid = 1'b1;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    s_a        = 4'hF;
    s_b        = 4'hF;
    lat = 0;
    while (!s_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("w4_latency", 64'(lat), 64'd2);
    chk("w4_product", 64'(s_z), 64'(exp));
    s_out_ready = 1'b1;
    @(posedge clk);
    #1;
    s_out_ready = 1'b0;
    chk("w4_post_hs_ready", 64'(s_in_ready), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] z;
    logic [31:0] ra;
    logic [31:0] rb;
    int          lat;
    int          seen;
    int          guard;

    vecs[0]  = '{32'h0000_0003, 32'h0000_0003, 0, 64'h9};
    vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001};
    vecs[2]  = '{32'h1234_5678, 32'h0000_0000, 0, 64'h0};
    vecs[3]  = '{32'h0000_0000, 32'hFFFF_FFFF, 2, 64'h0};
    vecs[4]  = '{32'h0000_0001, 32'h0000_0001, 0, 64'h1};
    vecs[5]  = '{32'h0000_FFFF, 32'h0000_FFFF, 5, 64'hFFFE_0001};
    vecs[6]  = '{32'h0001_0000, 32'h0001_0000, 0, 64'h1_0000_0000};
    vecs[7]  = '{32'h8000_0000, 32'h0000_0002, 3, 64'h1_0000_0000};
    vecs[8]  = '{32'h1234_5678, 32'h0000_0010, 0, 64'h1_2345_6780};
    vecs[9]  = '{32'h0000_0007, 32'h0000_0006, 1, 64'h2A};
    vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0002, 0, 64'h1_FFFF_FFFE};
    vecs[11] = '{32'h8000_0000, 32'h8000_0000, 0, 64'h4000_0000_0000_0000};
    vecs[12] = '{32'hAAAA_AAAA, 32'h0000_0003, 2, 64'h1_FFFF_FFFE};
    vecs[13] = '{32'h0000_FFFF, 32'h0001_0001, 0, 64'hFFFF_FFFF};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_z", out_z, 64'd0);
    chk("rst_w4_ready", 64'(s_in_ready), 64'd1);

    for (int i = 0; i < 14; i++) begin
      do_mul(vecs[i].a, vecs[i].b, vecs[i].bp, z, lat);
      chk($sformatf("vec%0d_product", i), z, vecs[i].z);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
    end

    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_mul(ra, rb, int'($urandom_range(0, 3)), z, lat);
      chk($sformatf("rnd%0d_product", i), z, 64'(ra) * 64'(rb));
    end

    // reset on the 7th CALC edge
    @(negedge clk);
    in_a     = 32'd5;
    in_b     = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("calc_busy", 64'(busy), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_calc_in_ready", 64'(in_ready), 64'd1);
    chk("rst_calc_out_z", out_z, 64'd0);
    chk("rst_calc_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("rst_calc_no_valid", 64'(seen), 64'd0);

    // reset while in DONE without a handshake
    @(negedge clk);
    in_a     = 32'd5;
    in_b     = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("done_valid", 64'(out_valid), 64'd1);
    chk("done_product", out_z, 64'h23);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_done_out_valid", 64'(out_valid), 64'd0);
    chk("rst_done_out_z", out_z, 64'd0);
    chk("rst_done_in_ready", 64'(in_ready), 64'd1);

    do_mul(32'd6, 32'd7, 0, z, lat);
    chk("recover_product", z, 64'h2A);
    chk("recover_latency", 64'(lat), 64'd16);

    do_mul4(4'd3, 4'd3, 8'h09);
    do_mul4(4'hF, 4'hF, 8'hE1);
    do_mul4(4'h0, 4'hF, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
